// File: rtl/alu_seq_if.sv
// Issue/completion bundle between register-file read, the sequential ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] or2_in;
    logic             sel_a;
    logic             sel_b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             illegal_op;

    modport master (
        output in_valid, op, a_in, b_in, or2_in, sel_a, sel_b,
        input  in_ready, out_valid, result, result_hi, flags, illegal_op
    );

    modport slave (
        input  in_valid, op, a_in, b_in, or2_in, sel_a, sel_b,
        output in_ready, out_valid, result, result_hi, flags, illegal_op
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: 16 legacy ops, iterative shift-add MUL, bit-serial rotates, CMP.
// Carry-in for ADC/SBC/RLC/RRC comes from the registered Carry flag.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    // state | meaning
    // IDLE  | ready; single-cycle ops complete on the accepting edge
    // ITER  | MUL or ROLN/RORN stepping one bit per edge while cnt counts down to 0
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic {IDLE, ITER} state_t;
    typedef enum logic [1:0] {K_MUL, K_ROL, K_ROR} kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d, illegal_q, illegal_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic [SH_W-1:0]  rot_n;
    logic             accept, cin, rot_c;
    logic [WIDTH:0]   leg_w, cmp_w, mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, rot_nx;

    function automatic logic [3:0] flag_of(input logic [WIDTH-1:0] r, input logic c);
        return {^r, ~r[WIDTH-1], c, ~|r};
    endfunction

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.result_hi  = result_hi_q;
    assign bus.flags      = flags_q;
    assign bus.illegal_op = illegal_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign op_a   = bus.sel_a ? bus.b_in : bus.a_in;
    assign op_b   = bus.sel_b ? bus.or2_in : bus.b_in;
    assign rot_n  = op_b[SH_W-1:0];
    assign cin    = flags_q[1];
    assign cmp_w  = {1'b0, op_b} - {1'b0, op_a};

    // Subtractions keep bit WIDTH of the wrapped difference, which is the borrow.
    always_comb begin
        leg_w = '0;
        case (bus.op[3:0])
            4'h1:    leg_w = {1'b0, op_a};
            4'h2:    leg_w = {1'b0, ~op_a};
            4'h3:    leg_w = {1'b0, op_b};
            4'h4:    leg_w = {1'b0, op_a} + ONE;
            4'h5:    leg_w = {1'b0, op_a} - ONE;
            4'h6:    leg_w = {op_a, cin};
            4'h7:    leg_w = {op_a[0], cin, op_a[WIDTH-1:1]};
            4'h8:    leg_w = {1'b0, op_a} + {1'b0, op_b};
            4'h9:    leg_w = {1'b0, op_b} - {1'b0, op_a};
            4'hA:    leg_w = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
            4'hB:    leg_w = {1'b0, op_b} - {1'b0, op_a} - {{WIDTH{1'b0}}, cin};
            4'hC:    leg_w = {1'b0, op_a & op_b};
            4'hD:    leg_w = {1'b0, op_a | op_b};
            4'hE:    leg_w = {1'b0, op_a ^ op_b};
            4'hF:    leg_w = {1'b0, ~(op_a ^ op_b)};
            default: leg_w = '0;
        endcase
    end

    // Shift-add step: {hi,lo} shifts right, multiplier bits leave lo as product bits enter.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign rot_nx    = (kind_q == K_ROL) ? {lo_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                         : {lo_q[0], lo_q[WIDTH-1:1]};
    assign rot_c     = (kind_q == K_ROL) ? lo_q[WIDTH-1] : lo_q[0];

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.op[4]) begin
                        result_d    = leg_w[WIDTH-1:0];
                        result_hi_d = '0;
                        flags_d     = flag_of(leg_w[WIDTH-1:0], leg_w[WIDTH]);
                        out_valid_d = 1'b1;
                    end else begin
                        case (bus.op[3:0])
                            4'h0: begin
                                if (MUL_EN) begin
                                    state_d = ITER;
                                    kind_d  = K_MUL;
                                    cnt_d   = CNT_W'(WIDTH);
                                    hi_d    = '0;
                                    lo_d    = op_b;
                                    mcand_d = op_a;
                                end else begin
                                    out_valid_d = 1'b1;
                                    illegal_d   = 1'b1;
                                end
                            end
                            4'h1, 4'h2: begin
                                if (rot_n == '0) begin
                                    result_d    = op_a;
                                    result_hi_d = '0;
                                    flags_d     = flag_of(op_a, cin);
                                    out_valid_d = 1'b1;
                                end else begin
                                    state_d = ITER;
                                    kind_d  = (bus.op[3:0] == 4'h1) ? K_ROL : K_ROR;
                                    cnt_d   = {1'b0, rot_n};
                                    lo_d    = op_a;
                                end
                            end
                            4'h3: begin
                                flags_d     = flag_of(cmp_w[WIDTH-1:0], cmp_w[WIDTH]);
                                out_valid_d = 1'b1;
                            end
                            default: begin
                                out_valid_d = 1'b1;
                                illegal_d   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (kind_q == K_MUL) begin
                    hi_d = mul_hi_nx;
                    lo_d = mul_lo_nx;
                end else begin
                    lo_d = rot_nx;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    if (kind_q == K_MUL) begin
                        result_d    = mul_lo_nx;
                        result_hi_d = mul_hi_nx;
                        flags_d     = flag_of(mul_lo_nx, |mul_hi_nx);
                    end else begin
                        result_d    = rot_nx;
                        result_hi_d = '0;
                        flags_d     = flag_of(rot_nx, rot_c);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q      <= K_MUL;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= 4'b0101;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: W=8 reference model plus a W=16, MUL_EN=0 instance.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if #(.WIDTH(8))  if1 ();
    alu_seq_if #(.WIDTH(16)) if2 ();

    alu_seq #(.WIDTH(8),  .MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(if1));
    alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic [7:0] r;
        logic [7:0] hi;
        logic [3:0] fl;
        logic       ill;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_r, m_hi;
    logic [3:0] m_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] fl_of(input logic [7:0] r, input logic c);
        return {^r, ~r[7], c, (r == 8'h00)};
    endfunction

    task automatic model_push(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [8:0]  x;
        logic [15:0] t;
        logic        c;
        int          n;
        int          lat;
        lat   = 1;
        e.ill = 1'b0;
        c     = m_fl[1];
        x     = '0;
        if (!op[4]) begin
            case (op[3:0])
                4'h1: x = {1'b0, a};
                4'h2: x = {1'b0, ~a};
                4'h3: x = {1'b0, b};
                4'h4: x = 9'(int'(a) + 1);
                4'h5: x = 9'(int'(a) - 1);
                4'h6: x = {a, c};
                4'h7: x = {a[0], c, a[7:1]};
                4'h8: x = 9'(int'(a) + int'(b));
                4'h9: x = 9'(int'(b) - int'(a));
                4'hA: x = 9'(int'(a) + int'(b) + int'(c));
                4'hB: x = 9'(int'(b) - int'(a) - int'(c));
                4'hC: x = {1'b0, a & b};
                4'hD: x = {1'b0, a | b};
                4'hE: x = {1'b0, a ^ b};
                4'hF: x = {1'b0, ~(a ^ b)};
                default: x = '0;
            endcase
            m_r = x[7:0]; m_hi = 8'h00; m_fl = fl_of(x[7:0], x[8]);
        end else if (op == 5'h10) begin
            t = 16'(a) * 16'(b);
            m_r = t[7:0]; m_hi = t[15:8]; m_fl = fl_of(t[7:0], |t[15:8]);
            lat = 9;
        end else if (op == 5'h11 || op == 5'h12) begin
            n = int'(b[2:0]);
            if (n == 0) begin
                m_r = a; m_hi = 8'h00; m_fl = fl_of(a, c);
            end else begin
                if (op == 5'h11) begin
                    t = {a, a} << n;
                    m_r = t[15:8];
                    m_fl = fl_of(m_r, m_r[0]);
                end else begin
                    t = {a, a} >> n;
                    m_r = t[7:0];
                    m_fl = fl_of(m_r, m_r[7]);
                end
                m_hi = 8'h00;
                lat = n + 1;
            end
        end else if (op == 5'h13) begin
            x = 9'(int'(b) - int'(a));
            m_fl = fl_of(x[7:0], x[8]);
        end else begin
            e.ill = 1'b1;
        end
        e.r = m_r; e.hi = m_hi; e.fl = m_fl; e.due = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] o2, input logic sa, input logic sbm);
        for (int i = 0; i < 40 && !if1.in_ready; i++) @(negedge clk);
        chk("ready_wait", if1.in_ready, 1);
        if1.op = op; if1.a_in = a; if1.b_in = b; if1.or2_in = o2;
        if1.sel_a = sa; if1.sel_b = sbm; if1.in_valid = 1'b1;
        model_push(op, sa ? b : a, sbm ? o2 : b);
        @(negedge clk);
        if1.in_valid = 1'b0;
    endtask

    task automatic issue2(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        if2.op = op; if2.a_in = a; if2.b_in = b; if2.or2_in = 16'h0;
        if2.sel_a = 1'b0; if2.sel_b = 1'b0; if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && if1.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("completion_cycle", cyc, e.due);
                chk("illegal_op", if1.illegal_op, e.ill);
                chk("result", if1.result, e.r);
                chk("result_hi", if1.result_hi, e.hi);
                chk("flags", if1.flags, e.fl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if1.in_valid = 0; if1.op = 0; if1.a_in = 0; if1.b_in = 0; if1.or2_in = 0;
        if1.sel_a = 0; if1.sel_b = 0;
        if2.in_valid = 0; if2.op = 0; if2.a_in = 0; if2.b_in = 0; if2.or2_in = 0;
        if2.sel_a = 0; if2.sel_b = 0;
        m_r = 8'h00; m_hi = 8'h00; m_fl = 4'b0101;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", if1.result, 0);
        chk("rst_result_hi", if1.result_hi, 0);
        chk("rst_flags", if1.flags, 4'b0101);
        chk("rst_in_ready", if1.in_ready, 1);
        chk("rst_out_valid", if1.out_valid, 0);
        chk("rst_illegal", if1.illegal_op, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD then ADC back-to-back: ADC sees the ADD carry
        issue(5'h08, 8'hFF, 8'h01, 8'h00, 0, 0);
        issue(5'h0A, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("adc_result", if1.result, 8'h01);
        chk("adc_flags", if1.flags, 4'b1100);

        issue(5'h09, 8'h05, 8'h03, 8'h00, 0, 0);
        @(negedge clk);
        issue(5'h13, 8'h05, 8'h03, 8'h00, 0, 0);
        chk("cmp_flags", if1.flags, 4'b1010);
        chk("cmp_result_held", if1.result, 8'hFE);

        issue(5'h09, 8'h00, 8'h10, 8'h30, 1, 1);

        issue(5'h10, 8'hFF, 8'hFF, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("mul_busy_ready", if1.in_ready, 0);
            if1.a_in = 8'($urandom); if1.b_in = 8'($urandom);
            @(negedge clk);
        end
        chk("mul_ov", if1.out_valid, 1);
        chk("mul_result", if1.result, 8'h01);
        chk("mul_result_hi", if1.result_hi, 8'hFE);
        chk("mul_carry", if1.flags[1], 1);
        issue(5'h10, 8'h0D, 8'h0B, 8'h07, 1, 1);

        issue(5'h11, 8'h81, 8'h03, 8'h00, 0, 0);
        issue(5'h08, 8'hFF, 8'h01, 8'h00, 0, 0);
        issue(5'h11, 8'h81, 8'h08, 8'h00, 0, 0);
        chk("rol0_result", if1.result, 8'h81);
        chk("rol0_carry", if1.flags[1], 1);
        issue(5'h12, 8'h01, 8'h01, 8'h00, 0, 0);

        issue(5'h15, 8'h12, 8'h34, 8'h00, 0, 0);
        chk("ill_pulse", if1.illegal_op, 1);
        chk("ill_result_held", if1.result, 8'h80);
        @(negedge clk);
        chk("ill_pulse_end", if1.illegal_op, 0);

        for (int i = 0; i < 12; i++)
            issue(5'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 40; i++)
            issue(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);

        // Reset during the third ITER cycle of a MUL
        issue(5'h10, 8'h37, 8'h5A, 8'h00, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        m_r = 8'h00; m_hi = 8'h00; m_fl = 4'b0101;
        #1;
        chk("mrst_result", if1.result, 0);
        chk("mrst_flags", if1.flags, 4'b0101);
        chk("mrst_in_ready", if1.in_ready, 1);
        chk("mrst_out_valid", if1.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mrst_no_ov", if1.out_valid, 0);
            @(negedge clk);
        end
        issue(5'h0A, 8'h01, 8'h01, 8'h00, 0, 0);

        issue2(5'h08, 16'h1234, 16'h0001);
        chk("w16_add_ov", if2.out_valid, 1);
        chk("w16_add_result", if2.result, 16'h1235);
        chk("w16_add_flags", if2.flags, 4'b0100);
        issue2(5'h10, 16'h0003, 16'h0005);
        chk("w16_mul_ov", if2.out_valid, 1);
        chk("w16_mul_illegal", if2.illegal_op, 1);
        chk("w16_mul_result_held", if2.result, 16'h1235);
        chk("w16_mul_flags_held", if2.flags, 4'b0100);
        chk("w16_mul_ready", if2.in_ready, 1);
        issue2(5'h12, 16'h0001, 16'h0010);
        chk("w16_ror0_ov", if2.out_valid, 1);
        chk("w16_ror0_result", if2.result, 16'h0001);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("final_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
